mdu_seq: RTL and testbench

Iterative unsigned multiply/divide sequencer for the multi-cycle core. It borrows the shared 32-bit ALU to perform 32 shift-add (MULTU) or restoring shift-subtract (DIVU) steps, producing HI/LO results. It sits beside the main control FSM, which stalls on `busy` and, while it does, hands the ALU operand/operation muxes to this block.

---
 rtl/mdu_seq_pkg.sv | 28 ++
 rtl/mdu_seq.sv | 171 +++++++++++++++++
 tb/tb_mdu_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer and its ALU hookup.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mdu_seq_pkg;

    // Operation codes understood by the shared 32-bit ALU.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Width of the step counter and the index of the final step.
    localparam int          CNT_W     = 6;
    localparam logic [5:0]  LAST_STEP = 6'd31;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_seq.sv
// Iterative unsigned MULTU/DIVU sequencer that borrows the shared ALU for 32 steps.
// Latency: 33 cycles from accepted start to the done pulse; 1 cycle for divide-by-zero.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter logic [2:0] ALU_ADD = OP_ADD,
    parameter logic [2:0] ALU_SUB = OP_SUB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_res,
    input  logic        alu_co
);

    mdu_state_t        r_state;
    mdu_state_t        w_next_state;

    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [31:0]       r_m;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_div_zero;

    logic              w_last_step;
    logic [63:0]       w_mul_nxt;
    logic [31:0]       w_div_hi_sh;
    logic              w_div_t;
    logic              w_div_take;
    logic [63:0]       w_div_nxt;

    assign w_last_step = (r_cnt == LAST_STEP);

    // MULTU step: conditionally add m into hi, then shift the 65-bit {carry,hi,lo} right.
    assign w_mul_nxt = r_lo[0] ? {alu_co, alu_res, r_lo[31:1]}
                               : {1'b0,   r_hi,    r_lo[31:1]};

    // DIVU step: shift {hi,lo} left; the ALU compares the shifted hi against m.
    // If the bit shifted out of hi was set, the partial remainder is already >= 2^32 > m,
    // so the subtraction must be taken regardless of the ALU borrow.
    assign w_div_hi_sh = {r_hi[30:0], r_lo[31]};
    assign w_div_t     = r_hi[31];
    assign w_div_take  = w_div_t | ~alu_co;
    assign w_div_nxt   = w_div_take ? {alu_res,     r_lo[30:0], 1'b1}
                                    : {w_div_hi_sh, r_lo[30:0], 1'b0};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: launch from IDLE, 32 steps, one DONE cycle, back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (!op) begin
                        w_next_state = ST_MUL;
                    end else if (b != 32'd0) begin
                        w_next_state = ST_DIV;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_last_step) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output logic: status flags and the ALU operand/operation drive.
    always_comb begin
        busy   = (r_state != ST_IDLE);
        done   = (r_state == ST_DONE);
        alu_op = ALU_ADD;
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        case (r_state)
            ST_MUL: begin
                alu_op = ALU_ADD;
                alu_a  = r_hi;
                alu_b  = r_m;
            end
            ST_DIV: begin
                alu_op = ALU_SUB;
                alu_a  = w_div_hi_sh;
                alu_b  = r_m;
            end
            default: begin
                alu_op = ALU_ADD;
                alu_a  = 32'd0;
                alu_b  = 32'd0;
            end
        endcase
    end

    // Datapath: operand capture on start, one shift-add/subtract step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_m        <= 32'd0;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m        <= b;
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                        if (!op) begin
                            r_m  <= a;
                            r_hi <= 32'd0;
                            r_lo <= b;
                        end else if (b != 32'd0) begin
                            r_hi <= 32'd0;
                            r_lo <= a;
                        end else begin
                            r_hi       <= a;
                            r_lo       <= 32'hFFFF_FFFF;
                            r_div_zero <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    {r_hi, r_lo} <= w_mul_nxt;
                    r_cnt        <= r_cnt + 6'd1;
                end
                ST_DIV: begin
                    {r_hi, r_lo} <= w_div_nxt;
                    r_cnt        <= r_cnt + 6'd1;
                end
                default: begin
                    // DONE: results hold for the consumer.
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq with a behavioural ALU and a result scoreboard.
// Latency: expects done 33 cycles after acceptance (1 cycle for divide-by-zero).
// Backpressure: stimulus waits for busy low before each start.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_co;

    always #5 clk = ~clk;

    mdu_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_res  (alu_res),
        .alu_co   (alu_co)
    );

    // Shared ALU: combinational, carry on add, borrow (A<B) on subtract.
    always_comb begin
        alu_res = 32'd0;
        alu_co  = 1'b0;
        case (alu_op)
            OP_ADD:  {alu_co, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  {alu_co, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_XOR:  alu_res = alu_a ^ alu_b;
            default: alu_res = 32'd0;
        endcase
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operands.
    function automatic exp_t ref_model(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        e.cyc = 0;
        if (!o) begin
            p    = {32'd0, x} * {32'd0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
        end else if (y == 32'd0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, e.hi});
                check("result_lo", {32'd0, lo}, {32'd0, e.lo});
                check("div_zero",  {63'd0, div_zero}, {63'd0, e.dz});
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_in_done", {63'd0, busy}, 64'd1);
            end
        end
    end

    task automatic wait_not_busy();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("busy_timeout", {63'd0, busy}, 64'd0);
    endtask

    // Issue one request at a negedge; expectation is pushed before acceptance.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        @(negedge clk);
        wait_not_busy();
        e     = ref_model(o, x, y);
        e.cyc = cyc + 1 + (e.dz ? 0 : 32);
        sb.push_back(e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check("busy_rise", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int          d0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ro;

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy",     {63'd0, busy}, 64'd0);
        check("rst_done",     {63'd0, done}, 64'd0);
        check("rst_hi",       {32'd0, hi}, 64'd0);
        check("rst_lo",       {32'd0, lo}, 64'd0);
        check("rst_div_zero", {63'd0, div_zero}, 64'd0);
        check("idle_alu_op",  {61'd0, alu_op}, {61'd0, OP_ADD});
        check("idle_alu_a",   {32'd0, alu_a}, 64'd0);
        check("idle_alu_b",   {32'd0, alu_b}, 64'd0);
        rst = 1'b0;

        // Directed corner cases.
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(1'b0, 32'd12345,     32'd0);
        issue(1'b0, 32'h8000_0000, 32'd2);
        issue(1'b1, 32'd100,       32'd7);
        issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
        issue(1'b1, 32'h0000_1234, 32'd0);
        issue(1'b0, 32'd3,         32'd5);
        wait_drain();

        // start while busy is dropped: exactly one done, original result.
        d0 = done_cnt;
        issue(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("ignored_start_done_count", 64'(done_cnt - d0), 64'd1);

        // Reset in the middle of a divide: no done, outputs cleared.
        d0 = done_cnt;
        issue(1'b1, 32'hCAFE_F00D, 32'd13);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hi",   {32'd0, hi}, 64'd0);
        check("midrst_lo",   {32'd0, lo}, 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        issue(1'b1, 32'hCAFE_F00D, 32'd13);
        wait_drain();

        // Randomized traffic, biased towards small and zero divisors.
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 16);
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb);
        end
        wait_drain();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
